// File: rtl/imem_pkg.sv
// Shared constants and the FIFO entry layout for the instruction prefetch buffer.
package imem_pkg;

    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0080;
    localparam int          MAX_OUTSTANDING   = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } imem_entry_t;

    localparam int ENTRY_W = $bits(imem_entry_t);

endpackage

// File: rtl/imem_fifo.sv
// Registered FIFO of fetched instructions; no bypass, so a push shows up on the head one cycle later.
module imem_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ENTRY_W-1:0]       wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ENTRY_W-1:0]       head
);

    localparam int PW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [PW:0]        count_q;

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher: OBI-style fetch with up to two requests in flight,
// PC-tagged instruction FIFO toward the decoder, and branch flush with response discard.
module imem_prefetch_buffer
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]        fetch_addr_q;
    logic [31:0]        resp_addr_q;
    logic [31:0]        held_addr_q;
    logic [1:0]         outstanding_q;
    logic [1:0]         outstanding_d;
    logic [1:0]         discard_q;
    logic               stale_q;
    logic               pending_q;
    logic [CW-1:0]      count_q;
    logic [CW:0]        fill;
    logic               credit;
    logic               granted;
    logic               push;
    logic               pop;
    logic [31:0]        branch_target;
    logic               unused_branch_lsbs;
    imem_entry_t        push_entry;
    imem_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_bits;

    assign branch_target      = {branch_addr_i[31:2], 2'b00};
    assign unused_branch_lsbs = ^branch_addr_i[1:0];

    // Credit counts in-flight requests against free FIFO slots so a push can never overflow.
    assign fill   = (CW+1)'(outstanding_q) + (CW+1)'(count_q);
    assign credit = req_i && (outstanding_q < 2'(MAX_OUTSTANDING)) && (fill < (CW+1)'(DEPTH));

    // A request already on the bus (pending or stale) stays up until granted.
    assign instr_req_o  = rst_ni && (stale_q || pending_q || credit);
    assign instr_addr_o = stale_q ? held_addr_q : fetch_addr_q;

    assign granted       = instr_req_o && instr_gnt_i;
    assign outstanding_d = outstanding_q + 2'(granted) - 2'(instr_rvalid_i);
    assign push          = instr_rvalid_i && !branch_i && (discard_q == 2'd0);
    assign valid_o       = (count_q != '0);
    assign pop           = valid_o && ready_i && !branch_i;
    assign busy_o        = (outstanding_q != 2'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q  <= BOOT_ADDR;
            resp_addr_q   <= BOOT_ADDR;
            held_addr_q   <= BOOT_ADDR;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
            stale_q       <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            pending_q     <= instr_req_o && !instr_gnt_i && !branch_i && !stale_q;
            if (branch_i) begin
                fetch_addr_q <= branch_target;
                resp_addr_q  <= branch_target;
                // Everything still owed after this cycle belongs to the old path.
                discard_q    <= outstanding_d;
                stale_q      <= instr_req_o && !instr_gnt_i;
                if (!stale_q) begin
                    held_addr_q <= fetch_addr_q;
                end
            end else begin
                if (granted && !stale_q) begin
                    fetch_addr_q <= fetch_addr_q + 32'd4;
                end
                if (push) begin
                    resp_addr_q <= resp_addr_q + 32'd4;
                end
                discard_q <= discard_q + 2'(stale_q && instr_gnt_i)
                                       - 2'(instr_rvalid_i && (discard_q != 2'd0));
                if (stale_q && instr_gnt_i) begin
                    stale_q <= 1'b0;
                end
            end
        end
    end

    assign push_entry.addr = resp_addr_q;
    assign push_entry.data = instr_rdata_i;
    assign push_entry.err  = instr_err_i;

    imem_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .flush (branch_i),
        .wdata (push_entry),
        .count (count_q),
        .head  (head_bits)
    );

    assign head_entry = head_bits;
    assign rdata_o    = head_entry.data;
    assign addr_o     = head_entry.addr;
    assign err_o      = head_entry.err;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed bench for imem_prefetch_buffer: per-cycle vector table driven against a small
// memory model with 1- or 2-cycle response latency, plus backpressure and reset sequences.
module tb_imem_prefetch_buffer;

    localparam logic [31:0] ERR_ADDR = 32'h0000_0088;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int row    = 0;
    int mem_lat = 1;

    always #5 clk_i = ~clk_i;

    imem_prefetch_buffer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory: answers each grant after mem_lat cycles; data is a fixed function of the address.
    logic [1:0]  pv;
    logic [31:0] pa0, pa1;
    logic [31:0] raddr;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv  <= 2'b00;
            pa0 <= '0;
            pa1 <= '0;
        end else begin
            pv[0] <= instr_req_o && instr_gnt_i;
            pa0   <= instr_addr_o;
            pv[1] <= pv[0];
            pa1   <= pa0;
        end
    end
    assign instr_rvalid_i = (mem_lat == 2) ? pv[1] : pv[0];
    assign raddr          = (mem_lat == 2) ? pa1 : pa0;
    assign instr_rdata_i  = instr_rvalid_i ? mem_word(raddr) : '0;
    assign instr_err_i    = instr_rvalid_i && (raddr == ERR_ADDR);

    typedef struct {
        bit          rst;
        int          lat;
        bit          req, gnt, rdy, br;
        logic [31:0] baddr;
        bit          e_ireq;
        logic [31:0] e_iaddr;
        bit          e_valid;
        logic [31:0] e_addr;
        bit          e_err;
        bit          e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(bit rst, int lat, bit req, bit gnt, bit rdy, bit br, logic [31:0] baddr,
                       bit e_ireq, logic [31:0] e_iaddr, bit e_valid, logic [31:0] e_addr,
                       bit e_err, bit e_busy);
        vec_t v;
        v.rst = rst; v.lat = lat; v.req = req; v.gnt = gnt; v.rdy = rdy; v.br = br;
        v.baddr = baddr; v.e_ireq = e_ireq; v.e_iaddr = e_iaddr; v.e_valid = e_valid;
        v.e_addr = e_addr; v.e_err = e_err; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        int grants;
        vec_t v;

        // Streaming, zero-wait grant, 1-cycle rvalid; 0x88 returns a bus error.
        add(1,1, 1,1,1,0,0,  0,32'h80,0,0,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h80,0,0,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h84,0,0,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h88,1,32'h80,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h8C,1,32'h84,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h90,1,32'h88,1,1);
        add(0,1, 1,1,1,0,0,  1,32'h94,1,32'h8C,0,1);
        // Backpressure: FIFO fills to 4, then ready resumes fetching.
        add(1,1, 1,1,0,0,0,  0,32'h80,0,0,0,0);
        add(0,1, 1,1,0,0,0,  1,32'h80,0,0,0,0);
        add(0,1, 1,1,0,0,0,  1,32'h84,0,0,0,1);
        add(0,1, 1,1,0,0,0,  1,32'h88,1,32'h80,0,1);
        add(0,1, 1,1,0,0,0,  1,32'h8C,1,32'h80,0,1);
        add(0,1, 1,1,0,0,0,  0,32'h90,1,32'h80,0,1);
        add(0,1, 1,1,1,0,0,  0,32'h90,1,32'h80,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h90,1,32'h84,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h94,1,32'h88,1,1);
        add(0,1, 1,1,1,0,0,  1,32'h98,1,32'h8C,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h9C,1,32'h90,0,1);
        // Branch to 0x1002 with two responses owed (2-cycle memory).
        add(1,2, 1,1,1,0,0,  0,32'h80,0,0,0,0);
        add(0,2, 1,1,1,0,0,  1,32'h80,0,0,0,0);
        add(0,2, 1,1,1,0,0,  1,32'h84,0,0,0,1);
        add(0,2, 1,1,1,1,32'h1002, 0,32'h88,0,0,0,1);
        add(0,2, 1,1,1,0,0,  1,32'h1000,0,0,0,1);
        add(0,2, 1,1,1,0,0,  1,32'h1004,0,0,0,1);
        add(0,2, 1,1,1,0,0,  0,32'h1008,0,0,0,1);
        add(0,2, 1,1,1,0,0,  1,32'h1008,1,32'h1000,0,1);
        add(0,2, 1,1,1,0,0,  1,32'h100C,1,32'h1004,0,1);
        // Ungranted request at 0x84 held through req_i low and a branch to 0x200.
        add(1,1, 1,1,1,0,0,  0,32'h80,0,0,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h80,0,0,0,0);
        add(0,1, 1,0,1,0,0,  1,32'h84,0,0,0,1);
        add(0,1, 0,0,1,0,0,  1,32'h84,1,32'h80,0,0);
        add(0,1, 1,0,1,1,32'h200, 1,32'h84,0,0,0,0);
        add(0,1, 1,0,1,0,0,  1,32'h84,0,0,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h84,0,0,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h200,0,0,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h204,0,0,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h208,1,32'h200,0,1);
        // Push, pop and branch together; target wraps past 2^32.
        add(1,1, 1,1,1,0,0,  0,32'h80,0,0,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h80,0,0,0,0);
        add(0,1, 1,1,1,0,0,  1,32'h84,0,0,0,1);
        add(0,1, 1,1,1,1,32'hFFFF_FFFE, 1,32'h88,1,32'h80,0,1);
        add(0,1, 1,1,1,0,0,  1,32'hFFFF_FFFC,0,0,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h0,0,0,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h4,1,32'hFFFF_FFFC,0,1);
        add(0,1, 1,1,1,0,0,  1,32'h8,1,32'h0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            row = i;
            @(negedge clk_i);
            rst_ni        = !v.rst;
            mem_lat       = v.lat;
            req_i         = v.req;
            instr_gnt_i   = v.gnt;
            ready_i       = v.rdy;
            branch_i      = v.br;
            branch_addr_i = v.baddr;
            #1;
            chk("instr_req", 32'(instr_req_o), 32'(v.e_ireq));
            chk("instr_addr", instr_addr_o, v.e_iaddr);
            chk("valid", 32'(valid_o), 32'(v.e_valid));
            chk("busy", 32'(busy_o), 32'(v.e_busy));
            if (v.e_valid) begin
                chk("head_addr", addr_o, v.e_addr);
                chk("head_err", 32'(err_o), 32'(v.e_err));
                chk("head_data", rdata_o, mem_word(v.e_addr));
            end
            if (v.rst) begin
                chk("rst_addr", addr_o, 32'h0);
                chk("rst_data", rdata_o, 32'h0);
                chk("rst_err", 32'(err_o), 32'h0);
            end
        end

        // Count grants under full backpressure, then reset with requests live.
        row = 1000;
        @(negedge clk_i);
        branch_i = 1'b0;
        rst_ni   = 1'b0;
        @(negedge clk_i);
        rst_ni      = 1'b1;
        mem_lat     = 1;
        req_i       = 1'b1;
        instr_gnt_i = 1'b1;
        ready_i     = 1'b0;
        grants      = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (instr_req_o && instr_gnt_i) grants++;
            if (c >= 2) chk("hold_head", addr_o, 32'h80);
            @(negedge clk_i);
        end
        chk("grant_count", 32'(grants), 32'd4);
        ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("resume_req", 32'(instr_req_o), 32'd1);
        chk("resume_head", addr_o, 32'h84);
        rst_ni = 1'b0;
        #1;
        chk("midrst_req", 32'(instr_req_o), 32'd0);
        chk("midrst_iaddr", instr_addr_o, 32'h80);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_addr", addr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_req", 32'(instr_req_o), 32'd1);
        chk("post_rst_valid", 32'(valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
